vram_arbiter: RTL and testbench

- Shares one port of the 8-bit video/system dual-port RAM between three requesters: the video fetcher (read-only), the Z80 CPU bus, and the ROM/cassette download loader.
- Sits between the requesters and the RAM port (enable, wren, address, data, q). That port has a registered read with 1-cycle latency.
- Video has fixed top priority. CPU and loader alternate round-robin.
- Each granted access is acknowledged exactly one cycle after it is issued, so the RAM port can start a new access every cycle.

---
 rtl/vram_arbiter_if.sv | 53 +++++
 rtl/vram_arbiter.sv | 121 ++++++++++++
 tb/tb_vram_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_arbiter_if.sv
// Requester and RAM-port signal bundle for vram_arbiter.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface vram_arbiter_if #(
  parameter int unsigned addr_width_g = 14
) ();
  logic                    vid_req;
  logic [addr_width_g-1:0] vid_addr;
  logic                    vid_ack;

  logic                    cpu_req;
  logic                    cpu_we;
  logic [addr_width_g-1:0] cpu_addr;
  logic [7:0]              cpu_wdata;
  logic                    cpu_ack;

  logic                    ldr_req;
  logic                    ldr_we;
  logic [addr_width_g-1:0] ldr_addr;
  logic [7:0]              ldr_wdata;
  logic                    ldr_ack;

  logic [7:0]              rdata;

  logic                    ram_enable;
  logic                    ram_wren;
  logic [addr_width_g-1:0] ram_address;
  logic [7:0]              ram_data;
  logic [7:0]              ram_q;

  modport slave (
    input  vid_req, vid_addr,
    output vid_ack,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack,
    input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
    output ldr_ack,
    output rdata,
    output ram_enable, ram_wren, ram_address, ram_data,
    input  ram_q
  );

  modport master (
    output vid_req, vid_addr,
    input  vid_ack,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack,
    output ldr_req, ldr_we, ldr_addr, ldr_wdata,
    input  ldr_ack,
    input  rdata,
    input  ram_enable, ram_wren, ram_address, ram_data,
    output ram_q
  );
endinterface

// File: rtl/vram_arbiter.sv
// Shares one registered-read RAM port between video (fixed top priority) and a
// round-robin CPU/loader pair; one access may issue per cycle, acked one cycle later.
module vram_arbiter #(
  parameter int unsigned addr_width_g = 14
) (
  input logic           clock,
  input logic           reset,
  vram_arbiter_if.slave bus_io
);

  typedef enum logic {
    RrCpu,
    RrLdr
  } rr_e;

  typedef enum logic [1:0] {
    GntNone,
    GntVid,
    GntCpu,
    GntLdr
  } gnt_e;

  rr_e  rr_q, rr_d;
  gnt_e gnt;

  // One-hot {ldr, cpu, vid}: whose access occupies the RAM port this cycle.
  logic [2:0] issued_q, issued_d;
  logic [2:0] ack_q, ack_d;

  logic                    ram_enable_q, ram_enable_d;
  logic                    ram_wren_q, ram_wren_d;
  logic [addr_width_g-1:0] ram_address_q, ram_address_d;
  logic [7:0]              ram_data_q, ram_data_d;

  logic elig_vid, elig_cpu, elig_ldr;

  // A requester is masked during its issue cycle so a held req cannot issue
  // again into its own ack cycle.
  always_comb begin
    elig_vid = bus_io.vid_req & ~issued_q[0];
    elig_cpu = bus_io.cpu_req & ~issued_q[1];
    elig_ldr = bus_io.ldr_req & ~issued_q[2];

    gnt = GntNone;
    if (elig_vid) begin
      gnt = GntVid;
    end else if (elig_cpu && elig_ldr) begin
      gnt = (rr_q == RrCpu) ? GntCpu : GntLdr;
    end else if (elig_cpu) begin
      gnt = GntCpu;
    end else if (elig_ldr) begin
      gnt = GntLdr;
    end
  end

  always_comb begin
    rr_d          = rr_q;
    issued_d      = 3'b000;
    ack_d         = issued_q;
    ram_enable_d  = 1'b0;
    ram_wren_d    = 1'b0;
    ram_address_d = ram_address_q;
    ram_data_d    = ram_data_q;

    unique case (gnt)
      GntVid: begin
        ram_enable_d  = 1'b1;
        ram_address_d = bus_io.vid_addr;
        issued_d      = 3'b001;
      end
      GntCpu: begin
        ram_enable_d  = 1'b1;
        ram_wren_d    = bus_io.cpu_we;
        ram_address_d = bus_io.cpu_addr;
        ram_data_d    = bus_io.cpu_wdata;
        issued_d      = 3'b010;
        rr_d          = RrLdr;
      end
      GntLdr: begin
        ram_enable_d  = 1'b1;
        ram_wren_d    = bus_io.ldr_we;
        ram_address_d = bus_io.ldr_addr;
        ram_data_d    = bus_io.ldr_wdata;
        issued_d      = 3'b100;
        rr_d          = RrCpu;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_q          <= RrCpu;
      issued_q      <= 3'b000;
      ack_q         <= 3'b000;
      ram_enable_q  <= 1'b0;
      ram_wren_q    <= 1'b0;
      ram_address_q <= '0;
      ram_data_q    <= 8'h00;
    end else begin
      rr_q          <= rr_d;
      issued_q      <= issued_d;
      ack_q         <= ack_d;
      ram_enable_q  <= ram_enable_d;
      ram_wren_q    <= ram_wren_d;
      ram_address_q <= ram_address_d;
      ram_data_q    <= ram_data_d;
    end
  end

  assign bus_io.vid_ack     = ack_q[0];
  assign bus_io.cpu_ack     = ack_q[1];
  assign bus_io.ldr_ack     = ack_q[2];
  assign bus_io.rdata       = bus_io.ram_q;
  assign bus_io.ram_enable  = ram_enable_q;
  assign bus_io.ram_wren    = ram_wren_q;
  assign bus_io.ram_address = ram_address_q;
  assign bus_io.ram_data    = ram_data_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: RAM model, issue-history reference model, vector table,
// directed corner sequences and a randomized phase.
module tb_vram_arbiter;
  localparam int unsigned AW = 14;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  vram_arbiter_if #(.addr_width_g(AW)) bus_if ();

  vram_arbiter #(.addr_width_g(AW)) dut (
    .clock  (clock),
    .reset  (reset),
    .bus_io (bus_if.slave)
  );

  // RAM port with 1-cycle registered read; ignores reset.
  logic [7:0] ram_mem [0:(1<<AW)-1];
  bit mem_clear = 1'b1;
  always @(posedge clock) begin
    if (mem_clear) begin
      for (int i = 0; i < (1 << AW); i++) ram_mem[i] <= 8'h00;
    end else if (bus_if.ram_enable) begin
      if (bus_if.ram_wren) ram_mem[bus_if.ram_address] <= bus_if.ram_data;
      else bus_if.ram_q <= ram_mem[bus_if.ram_address];
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: 0=video 1=cpu 2=loader, -1=none.
  logic [7:0]    ref_mem [0:(1<<AW)-1];
  int            m_issued = -1;
  bit            m_iss_we;
  logic [AW-1:0] m_addr = '0;
  logic [7:0]    m_data;
  logic [7:0]    m_iss_rd;
  int            m_ack = -1;
  bit            m_ack_we;
  logic [7:0]    m_ack_rd;
  int            m_lastcl = 2;

  function automatic int pick();
    bit ev, ec, el;
    ev = bus_if.vid_req && (m_issued != 0);
    ec = bus_if.cpu_req && (m_issued != 1);
    el = bus_if.ldr_req && (m_issued != 2);
    if (ev) return 0;
    if (ec && el) return (m_lastcl == 1) ? 2 : 1;
    if (ec) return 1;
    if (el) return 2;
    return -1;
  endfunction

  task automatic cycle();
    int g;
    if (reset) begin
      m_issued = -1;
      m_ack    = -1;
      m_iss_we = 1'b0;
      m_addr   = '0;
      m_lastcl = 2;
    end else begin
      g        = pick();
      m_ack    = m_issued;
      m_ack_we = m_iss_we;
      m_ack_rd = m_iss_rd;
      m_issued = g;
      m_iss_we = 1'b0;
      if (g == 0) begin
        m_addr = bus_if.vid_addr;
      end else if (g == 1) begin
        m_addr = bus_if.cpu_addr; m_data = bus_if.cpu_wdata; m_iss_we = bus_if.cpu_we;
      end else if (g == 2) begin
        m_addr = bus_if.ldr_addr; m_data = bus_if.ldr_wdata; m_iss_we = bus_if.ldr_we;
      end
      if (g >= 0) begin
        m_iss_rd = ref_mem[m_addr];
        if (m_iss_we) ref_mem[m_addr] = m_data;
        if (g != 0) m_lastcl = g;
      end
    end
    @(posedge clock);
    #1;
    chk("ram_enable", 32'(bus_if.ram_enable), 32'(m_issued >= 0));
    chk("ram_wren", 32'(bus_if.ram_wren), 32'((m_issued >= 0) && m_iss_we));
    chk("ram_address", 32'(bus_if.ram_address), 32'(m_addr));
    if (m_issued >= 0 && m_iss_we) chk("ram_data", 32'(bus_if.ram_data), 32'(m_data));
    chk("vid_ack", 32'(bus_if.vid_ack), 32'(m_ack == 0));
    chk("cpu_ack", 32'(bus_if.cpu_ack), 32'(m_ack == 1));
    chk("ldr_ack", 32'(bus_if.ldr_ack), 32'(m_ack == 2));
    if (m_ack >= 0 && !m_ack_we) chk("rdata", 32'(bus_if.rdata), 32'(m_ack_rd));
  endtask

  task automatic clear_reqs();
    bus_if.vid_req = 1'b0;
    bus_if.cpu_req = 1'b0;
    bus_if.ldr_req = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_reqs();
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  function automatic logic [AW-1:0] addr_of(input int r);
    case (r)
      0:       return 14'h1000;
      1:       return 14'h0200;
      default: return 14'h0030;
    endcase
  endfunction

  typedef struct {
    bit v, c, l;
    int first, second;
  } vec_t;
  vec_t vecs [8];

  initial begin
    int i, j;
    bit vf, cf, lf;
    vecs[0] = '{1, 1, 1, 0, 1};
    vecs[1] = '{0, 1, 1, 1, 2};
    vecs[2] = '{1, 0, 1, 0, 2};
    vecs[3] = '{1, 1, 0, 0, 1};
    vecs[4] = '{0, 0, 1, 2, -1};
    vecs[5] = '{1, 0, 0, 0, -1};
    vecs[6] = '{0, 1, 0, 1, -1};
    vecs[7] = '{0, 0, 0, -1, -1};

    for (int k = 0; k < (1 << AW); k++) ref_mem[k] = 8'h00;
    clear_reqs();
    bus_if.vid_addr  = '0;
    bus_if.cpu_we    = 1'b0;
    bus_if.cpu_addr  = '0;
    bus_if.cpu_wdata = 8'h00;
    bus_if.ldr_we    = 1'b0;
    bus_if.ldr_addr  = '0;
    bus_if.ldr_wdata = 8'h00;
    do_reset();
    mem_clear = 1'b0;
    chk("reset_enable", 32'(bus_if.ram_enable), 32'd0);
    chk("reset_address", 32'(bus_if.ram_address), 32'd0);
    chk("reset_data", 32'(bus_if.ram_data), 32'd0);

    // CPU write then read-back.
    bus_if.cpu_req = 1'b1; bus_if.cpu_we = 1'b1;
    bus_if.cpu_addr = 14'h0123; bus_if.cpu_wdata = 8'h5A;
    cycle();
    chk("wr_issue_en", 32'(bus_if.ram_enable), 32'd1);
    chk("wr_issue_wren", 32'(bus_if.ram_wren), 32'd1);
    chk("wr_issue_addr", 32'(bus_if.ram_address), 32'h0123);
    cycle();
    chk("wr_ack", 32'(bus_if.cpu_ack), 32'd1);
    bus_if.cpu_req = 1'b0;
    cycle();
    bus_if.cpu_req = 1'b1; bus_if.cpu_we = 1'b0;
    cycle();
    cycle();
    chk("rd_ack", 32'(bus_if.cpu_ack), 32'd1);
    chk("rd_data", 32'(bus_if.rdata), 32'h5A);
    bus_if.cpu_req = 1'b0;
    cycle();

    // Priority table from a fresh reset; all reads at distinct addresses.
    bus_if.vid_addr = addr_of(0); bus_if.cpu_addr = addr_of(1); bus_if.ldr_addr = addr_of(2);
    bus_if.cpu_we = 1'b0; bus_if.ldr_we = 1'b0;
    for (int t = 0; t < 8; t++) begin
      do_reset();
      bus_if.vid_req = vecs[t].v; bus_if.cpu_req = vecs[t].c; bus_if.ldr_req = vecs[t].l;
      cycle();
      chk("tbl_en1", 32'(bus_if.ram_enable), 32'(vecs[t].first >= 0));
      if (vecs[t].first >= 0) chk("tbl_addr1", 32'(bus_if.ram_address), 32'(addr_of(vecs[t].first)));
      cycle();
      chk("tbl_en2", 32'(bus_if.ram_enable), 32'(vecs[t].second >= 0));
      if (vecs[t].second >= 0)
        chk("tbl_addr2", 32'(bus_if.ram_address), 32'(addr_of(vecs[t].second)));
      chk("tbl_ack", 32'({bus_if.ldr_ack, bus_if.cpu_ack, bus_if.vid_ack}),
          (vecs[t].first >= 0) ? (32'd1 << vecs[t].first) : 32'd0);
      clear_reqs();
      cycle();
      cycle();
    end

    // All three held: V C V L ...; CPU/loader only: C L C L.
    do_reset();
    bus_if.vid_req = 1'b1; bus_if.cpu_req = 1'b1; bus_if.ldr_req = 1'b1;
    for (int t = 0; t < 12; t++) cycle();
    clear_reqs();
    cycle(); cycle();
    do_reset();
    bus_if.cpu_req = 1'b1; bus_if.ldr_req = 1'b1;
    for (int t = 0; t < 8; t++) begin
      cycle();
      chk("cl_alt", 32'(bus_if.ram_address), 32'(addr_of((t % 2 == 0) ? 1 : 2)));
    end
    clear_reqs();
    cycle(); cycle();

    // Idle for 10 cycles.
    for (int t = 0; t < 10; t++) begin
      cycle();
      chk("idle_en", 32'(bus_if.ram_enable), 32'd0);
      chk("idle_acks", 32'({bus_if.ldr_ack, bus_if.cpu_ack, bus_if.vid_ack}), 32'd0);
    end

    // Loader fills 0x3FF0..0x3FFF while video sweeps the same range.
    i = 0; j = 0;
    bus_if.ldr_req = 1'b1; bus_if.ldr_we = 1'b1;
    bus_if.ldr_addr = 14'h3FF0; bus_if.ldr_wdata = 8'h00;
    bus_if.vid_req = 1'b1; bus_if.vid_addr = 14'h3FF0;
    for (int t = 0; t < 400 && i < 16; t++) begin
      cycle();
      if (bus_if.ldr_ack) begin
        i++;
        if (i < 16) begin
          bus_if.ldr_addr = 14'(14'h3FF0 + i); bus_if.ldr_wdata = 8'(i);
        end else begin
          bus_if.ldr_req = 1'b0;
        end
      end
      if (bus_if.vid_ack) begin
        j = (j + 1) % 16;
        bus_if.vid_addr = 14'(14'h3FF0 + j);
      end
    end
    chk("ldr_fill_done", 32'(i), 32'd16);
    bus_if.vid_req = 1'b0;
    cycle(); cycle();
    bus_if.vid_req = 1'b1;
    for (int k = 0; k < 16; k++) begin
      bus_if.vid_addr = 14'(14'h3FF0 + k);
      cycle();
      cycle();
      chk("vid_sweep_ack", 32'(bus_if.vid_ack), 32'd1);
      chk("vid_sweep_data", 32'(bus_if.rdata), 32'(k));
    end
    bus_if.vid_req = 1'b0;
    cycle(); cycle();

    // Reset during the issue cycle of a CPU read.
    bus_if.cpu_req = 1'b1; bus_if.cpu_we = 1'b0; bus_if.cpu_addr = 14'h0123;
    cycle();
    chk("rst_rd_issue", 32'(bus_if.ram_enable), 32'd1);
    bus_if.cpu_req = 1'b0;
    reset = 1'b1;
    cycle();
    chk("rst_no_ack1", 32'(bus_if.cpu_ack), 32'd0);
    chk("rst_en_low", 32'(bus_if.ram_enable), 32'd0);
    cycle();
    chk("rst_no_ack2", 32'(bus_if.cpu_ack), 32'd0);
    reset = 1'b0;
    bus_if.cpu_req = 1'b1; bus_if.ldr_req = 1'b1;
    bus_if.cpu_addr = 14'h0222; bus_if.ldr_addr = 14'h0333; bus_if.ldr_we = 1'b0;
    cycle();
    chk("rst_cpu_wins", 32'(bus_if.ram_address), 32'h0222);
    chk("rst_no_stale_ack", 32'(bus_if.cpu_ack), 32'd0);
    cycle();
    clear_reqs();
    cycle(); cycle();

    // Randomized traffic; a requester re-randomizes only when idle or acked.
    for (int t = 0; t < 500; t++) begin
      vf = !bus_if.vid_req || bus_if.vid_ack;
      cf = !bus_if.cpu_req || bus_if.cpu_ack;
      lf = !bus_if.ldr_req || bus_if.ldr_ack;
      if (vf) begin
        bus_if.vid_req  = ($urandom_range(0, 2) != 0);
        bus_if.vid_addr = 14'($urandom_range(0, 15));
      end
      if (cf) begin
        bus_if.cpu_req   = ($urandom_range(0, 2) != 0);
        bus_if.cpu_we    = 1'($urandom_range(0, 1));
        bus_if.cpu_addr  = 14'($urandom_range(0, 15));
        bus_if.cpu_wdata = 8'($urandom);
      end
      if (lf) begin
        bus_if.ldr_req   = ($urandom_range(0, 2) != 0);
        bus_if.ldr_we    = 1'($urandom_range(0, 1));
        bus_if.ldr_addr  = 14'($urandom_range(0, 15));
        bus_if.ldr_wdata = 8'($urandom);
      end
      cycle();
    end
    clear_reqs();
    cycle(); cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
